// File: rtl/result_drain.sv
// Drains the 4x4 C result matrix from the controller after each done edge and
// streams it row-major over valid/ready, using a small credit-managed FIFO.
module result_drain #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int N_ELEMS    = 16,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done,
    output logic [ADDR_W-1:0] read_addr_C,
    input  logic [DATA_W-1:0] read_data_C,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_index,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              drain_done,
    output logic              overrun
);

    localparam int CNT_W = $clog2(N_ELEMS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ELEMS - 1);
    localparam logic [3:0]       LAST_IDX = 4'(N_ELEMS - 1);
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic                done_q;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic                inflight_q, inflight_d;
    logic [3:0]          inflight_idx_q, inflight_idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                overrun_q, overrun_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0]   mem_data_q [FIFO_DEPTH];
    logic [3:0]          mem_idx_q  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;

    logic             start;
    logic             credit;
    logic             issue;
    logic             push;
    logic             pop;
    logic             fin;
    logic [CNT_W-1:0] cur_cnt;

    always_comb begin
        start   = done && !done_q;
        // In IDLE the first read goes out in the start cycle itself, always element 0
        cur_cnt = (state_q == ISSUE) ? issue_cnt_q : '0;
        // Credit ignores a same-cycle pop so a stalled consumer can never overflow us
        credit  = (fifo_cnt_q + OCC_W'(inflight_q)) < DEPTH_C;
        fin     = (state_q == FLUSH) && !inflight_q && (fifo_cnt_q == '0);

        issue       = 1'b0;
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    issue     = 1'b1;
                    overrun_d = 1'b0;
                end
            end
            ISSUE: begin
                issue = credit;
                if (start) overrun_d = 1'b1;
            end
            FLUSH: begin
                if (start) overrun_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            issue_cnt_d = cur_cnt + CNT_W'(1);
            state_d     = (cur_cnt == LAST_CNT) ? FLUSH : ISSUE;
        end
        if (fin) begin
            state_d     = IDLE;
            issue_cnt_d = '0;
        end

        read_addr_C    = issue ? (ADDR_W'(BASE_ADDR) + ADDR_W'(cur_cnt)) : addr_q;
        addr_d         = read_addr_C;
        inflight_d     = issue;
        inflight_idx_d = issue ? 4'(cur_cnt) : inflight_idx_q;

        push       = inflight_q;
        out_valid  = (fifo_cnt_q != '0);
        pop        = out_valid && out_ready;
        wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + OCC_W'(push) - OCC_W'(pop);

        out_data   = mem_data_q[rd_ptr_q];
        out_index  = mem_idx_q[rd_ptr_q];
        out_last   = mem_last_q[rd_ptr_q];
        busy       = (state_q != IDLE);
        drain_done = fin;
        overrun    = overrun_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            done_q         <= 1'b0;
            issue_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            addr_q         <= ADDR_W'(BASE_ADDR);
            overrun_q      <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            mem_last_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_idx_q[i]  <= '0;
            end
        end else begin
            state_q        <= state_d;
            done_q         <= done;
            issue_cnt_q    <= issue_cnt_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            addr_q         <= addr_d;
            overrun_q      <= overrun_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            // Read data lands one cycle after its address and is tagged with its element index
            if (push) begin
                mem_data_q[wr_ptr_q] <= read_data_C;
                mem_idx_q[wr_ptr_q]  <= inflight_idx_q;
                mem_last_q[wr_ptr_q] <= (inflight_idx_q == LAST_IDX);
            end
        end
    end

endmodule
